mult_share_arbiter: RTL
=======================

// Module: mult_share_arbiter
// PURPOSE
//   Shares one combinational 4x4 array multiplier among NREQ requesters.
//   Round-robin grant; valid/ready handshake on each request port and on the single response port.
//   Operands are registered into the multiplier and the product is captured, tagged with the requester ID.
//   Sits between client blocks and the array multiplier instance (mul_a/mul_b -> a/b, p -> mul_p).
// PARAMETERS
//   NREQ   4              number of requesters (>=2, need not be a power of 2)
//   W      4              operand width; product width is 2*W
//   IDW    $clog2(NREQ)   requester ID width (derived, do not override)
// PORTS
//   clk        in   1        clock, all state on rising edge
//   rst_n      in   1        synchronous active-low reset
//   req_valid  in   NREQ     request i valid; held until req_ready[i]
//   req_ready  out  NREQ     grant/accept strobe, one-hot or zero
//   req_a      in   NREQ*W   operand A, requester i at [i*W +: W]
//   req_b      in   NREQ*W   operand B, requester i at [i*W +: W]
//   mul_a      out  W        to multiplier input a (registered)
//   mul_b      out  W        to multiplier input b (registered)
//   mul_p      in   2*W      from multiplier output p (combinational)
//   rsp_valid  out  1        result valid
//   rsp_ready  in   1        result consumer ready
//   rsp_p      out  2*W      product, unsigned
//   rsp_id     out  IDW      index of requester that issued this product
//   busy       out  1        high whenever state != IDLE
//   ops_done   out  8        completed-response counter, wraps 255->0
// BEHAVIOUR
//   Reset (rst_n=0 at clk edge): state=IDLE, ptr=0, all outputs 0.
//     Any in-flight op is discarded; no response is emitted for it.
//   Arbitration:
//     Grant g = first i with req_valid[i], searching ptr, ptr+1, ... mod NREQ.
//     req_ready is combinational from req_valid and state; req_ready[g]=1 only when the FSM can accept.
//     Accept = req_valid[g] & req_ready[g].
//     On accept: mul_a<=req_a[g], mul_b<=req_b[g], id<=g, ptr<=(g==NREQ-1)?0:g+1.
//   FSM:
//     IDLE: accept allowed. On accept -> CALC. Otherwise stay.
//     CALC: one cycle. rsp_p<=mul_p, rsp_id<=id, rsp_valid<=1 -> RESP. No accept.
//     RESP: rsp_valid=1; rsp_p and rsp_id stable until handshake.
//       rsp_ready=0: stay; no accept.
//       rsp_ready=1: ops_done<=ops_done+1.
//         If any req_valid: accept in the same cycle -> CALC (rsp_valid drops for 1 cycle).
//         Else: rsp_valid<=0 -> IDLE.
//   Timing:
//     Latency: accept at edge t -> rsp_valid=1 after edge t+1.
//     Throughput: 1 result per 2 cycles with continuous rsp_ready.
//   Arithmetic: rsp_p = req_a*req_b unsigned, full 2*W bits, no truncation. Max 15*15=225 for W=4.
//   Boundaries:
//     ptr wraps NREQ-1 -> 0.
//     Only one valid requester: it is granted each opportunity regardless of ptr.
//     No valid requesters: req_ready=0, FSM idles.
//     Requester dropping req_valid before ready: protocol violation; the block need not handle it.
//     ops_done wraps silently.
//     rsp_ready high while rsp_valid=0: ignored.
// TESTING
//   Single op:
//     req_valid=0001, a0=7, b0=9 -> req_ready=0001 that cycle.
//     rsp_valid 2 edges later with rsp_p=63, rsp_id=0; ops_done=1 after rsp_ready.
//   Round-robin:
//     All 4 requesters valid continuously with rsp_ready=1 -> grant order 0,1,2,3,0.
//     Each product correct, one result every 2 cycles.
//   Backpressure:
//     rsp_ready=0 for 5 cycles with a=15, b=15 -> rsp_p=225 held stable, req_ready=0 throughout.
//     Releases on rsp_ready=1.
//   Fairness after partial grant:
//     Grant req2, then only req1 and req3 valid -> req3 granted before req1.
//   Reset mid-op:
//     rst_n=0 while in CALC -> next cycle rsp_valid=0, busy=0, ptr=0, ops_done=0.
//     No stale response after reset release.
//   Exhaustive operands:
//     All 256 (a,b) pairs through requester 3 -> every rsp_p==a*b, rsp_id=3.

Source files
------------

// File: rtl/mult_share_arbiter.sv
// Round-robin front end that time-shares one external combinational W x W multiplier
// among NREQ requesters. Each accepted request returns one ID-tagged product on the response port.
module mult_share_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*W-1:0]   req_a,
  input  logic [NREQ*W-1:0]   req_b,
  output logic [W-1:0]        mul_a,
  output logic [W-1:0]        mul_b,
  input  logic [2*W-1:0]      mul_p,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [2*W-1:0]      rsp_p,
  output logic [IDW-1:0]      rsp_id,
  output logic                busy,
  output logic [7:0]          ops_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] id;
  logic [IDW-1:0] grant;
  logic           any_valid;
  logic           can_accept;
  logic           accept;

  logic [W-1:0] a_arr [NREQ];
  logic [W-1:0] b_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*W +: W];
    assign b_arr[i] = req_b[i*W +: W];
  end

  // First valid requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    int idx;
    // NOTE: every variable gets a default before any conditional write so no latch is inferred.
    any_valid = 1'b0;
    grant     = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any_valid && req_valid[IDW'(idx)]) begin
        any_valid = 1'b1;
        grant     = IDW'(idx);
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = accept ? CALC : IDLE;
      CALC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = accept ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: a new op may start when idle, or when the held result is being taken.
  always_comb begin
    can_accept = (state == IDLE) || ((state == RESP) && rsp_ready);
    accept     = can_accept && any_valid;
    busy       = (state != IDLE);
    req_ready  = '0;
    if (accept) req_ready[grant] = 1'b1;
  end

  // Datapath: operand capture, product capture, response handshake, completion count.
  always_ff @(posedge clk) begin
    // NOTE: datapath registers are reset too, since every output must read zero out of reset.
    if (!rst_n) begin
      ptr       <= '0;
      id        <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_p     <= '0;
      rsp_id    <= '0;
      ops_done  <= '0;
    end else begin
      if (accept) begin
        mul_a <= a_arr[grant];
        mul_b <= b_arr[grant];
        id    <= grant;
        ptr   <= (grant == IDW'(NREQ-1)) ? '0 : grant + 1'b1;
      end
      if (state == CALC) begin
        rsp_p     <= mul_p;
        rsp_id    <= id;
        rsp_valid <= 1'b1;
      end
      if ((state == RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
        ops_done  <= ops_done + 8'd1;
      end
    end
  end

endmodule
